// File: rtl/msk_seq_pkg.sv
// msk_seq_pkg: state encoding and width helper shared by the masked block sequencer
package msk_seq_pkg;
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  function automatic int cnt_w(input int nw);
    return $clog2(nw + 1);
  endfunction
endpackage

// File: rtl/msk_word_slot.sv
// msk_word_slot: one masked word register with independent load and clear
module msk_word_slot #(
  parameter int WD = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic          clr,
  input  logic [WD-1:0] din,
  output logic [WD-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (ld) q <= din;
endmodule

// File: rtl/msk_block_seq.sv
// msk_block_seq: packs masked words into NW-word blocks; MSK_BLOCK_SEQ_PAD_EN selects a 1-marker pad word
module msk_block_seq
  import msk_seq_pkg::*;
#(
  parameter int d  = 2,
  parameter int W  = 32,
  parameter int NW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W*d-1:0]         in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [NW*W*d-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [cnt_w(NW)-1:0]   out_nwords,
  output logic                   out_last
);
  localparam int WD = W * d;
  localparam int CW = cnt_w(NW);
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
`ifdef MSK_BLOCK_SEQ_PAD_EN
  localparam logic [WD-1:0] PAD = WD'(1);
`else
  localparam logic [WD-1:0] PAD = '0;
`endif
  state_t state;
  logic [CW-1:0] wcnt, nxt;
  logic acc, close, part;
  assign in_ready  = state != FULL;
  assign out_valid = state == FULL;
  assign acc   = in_valid & in_ready;
  assign nxt   = wcnt + 1'b1;
  assign close = acc & (in_last | wcnt == LAST);
  assign part  = acc & in_last & wcnt != LAST;
  // padding is written in the same edge as the closing word; first pad slot may carry the marker
  for (genvar k = 0; k < NW; k++) begin : g_slot
    logic hit, pad_one, clr;
    assign hit     = acc && wcnt == CW'(k);
    assign pad_one = part && nxt == CW'(k);
    assign clr     = part && CW'(k) > nxt;
    msk_word_slot #(.WD(WD)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   (hit | pad_one),
      .clr  (clr),
      .din  (hit ? in_data : PAD),
      .q    (out_data[k*WD +: WD])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      wcnt       <= '0;
      out_nwords <= '0;
      out_last   <= 1'b0;
    end else if (state == FULL) begin
      if (out_ready) begin
        state <= IDLE;
        wcnt  <= '0;
      end
    end else if (acc) begin
      wcnt  <= nxt;
      state <= close ? FULL : FILL;
      if (close) begin
        out_nwords <= nxt;
        out_last   <= in_last;
      end
    end
endmodule

// File: tb/tb_msk_block_seq.sv
// tb_msk_block_seq: scoreboard bench for the masked block sequencer
module tb_msk_block_seq;
  localparam int D = 2, W = 32, NW = 4, WD = W * D, BW = NW * WD;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [WD-1:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [BW-1:0] out_data;
  logic [2:0] out_nwords;

  msk_block_seq #(.d(D), .W(W), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_nwords(out_nwords), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [2:0] nw;
    logic last;
    logic [NW-1:0][W-1:0] plain;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0, xfers = 0;
  logic [BW-1:0] cur_data = '0;
  logic [NW-1:0][W-1:0] cur_plain = '0;
  int cur_n = 0;

  function automatic logic [WD-1:0] mask(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [WD-1:0] m;
    r = $urandom;
    for (int i = 0; i < W; i++) begin
      m[2*i]   = r[i];
      m[2*i+1] = v[i] ^ r[i];
    end
    return m;
  endfunction

  function automatic logic [W-1:0] unmask(input logic [WD-1:0] x);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = x[2*i] ^ x[2*i+1];
    return v;
  endfunction

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      xfers++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block got out_valid transfer required none");
      end else begin
        mon_e = q.pop_front();
        if (out_data !== mon_e.data) begin
          errors++;
          $display("FAIL block_data got %h required %h", out_data, mon_e.data);
        end
        checks++;
        if (out_nwords !== mon_e.nw) begin
          errors++;
          $display("FAIL out_nwords got %0d required %0d", out_nwords, mon_e.nw);
        end
        checks++;
        if (out_last !== mon_e.last) begin
          errors++;
          $display("FAIL out_last got %b required %b", out_last, mon_e.last);
        end
        for (int i = 0; i < NW; i++)
          if (i < int'(mon_e.nw)) begin
            checks++;
            if (unmask(out_data[i*WD +: WD]) !== mon_e.plain[i]) begin
              errors++;
              $display("FAIL share_xor word %0d got %h required %h", i, unmask(out_data[i*WD +: WD]), mon_e.plain[i]);
            end
          end
      end
    end

  task automatic push_block(input logic last);
    exp_t e;
    e.data = cur_data;
`ifdef MSK_BLOCK_SEQ_PAD_EN
    if (cur_n < NW) e.data[cur_n*WD] = 1'b1;
`endif
    e.nw = 3'(cur_n);
    e.last = last;
    e.plain = cur_plain;
    q.push_back(e);
    cur_data = '0;
    cur_plain = '0;
    cur_n = 0;
  endtask

  task automatic send(input logic [W-1:0] v, input logic last);
    logic ok;
    int n;
    logic [WD-1:0] m;
    m = mask(v);
    in_valid = 1'b1; in_data = m; in_last = last;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept got in_ready=0 required 1 within 50 cycles");
    end else begin
      cur_data[cur_n*WD +: WD] = m;
      cur_plain[cur_n] = v;
      cur_n++;
      if (last || cur_n == NW) begin
        push_block(last);
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL out_valid_latency got %b required 1", out_valid);
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending blocks required 0", q.size());
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_nwords !== 3'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s got v=%b r=%b n=%0d l=%b data=%h required v=0 r=1 n=0 l=0 data=0",
               tag, out_valid, in_ready, out_nwords, out_last, out_data);
    end
  endtask

  task automatic test_reset();
    #3;
    check_idle("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_block();
    send(32'h0000_000A, 1'b0);
    send(32'h0000_000B, 1'b0);
    send(32'h0000_000C, 1'b0);
    send(32'h0000_000D, 1'b0);
    wait_drain();
  endtask

  task automatic test_partial();
    send(32'hAAAA_0001, 1'b0);
    send(32'hBBBB_0002, 1'b1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b0);
    send(32'h4444_4444, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== q[$].data) begin
        errors++;
        $display("FAIL hold cycle %0d got r=%b v=%b data=%h required r=0 v=1 data=%h",
                 i, in_ready, out_valid, out_data, q[$].data);
      end
    end
    out_ready = 1'b1;
    wait_drain();
    send(32'h5555_5555, 1'b1);
    wait_drain();
  endtask

  task automatic test_single();
    int n0;
    n0 = xfers;
    send(32'hDEAD_BEEF, 1'b1);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (xfers != n0 + 1) begin
      errors++;
      $display("FAIL single_xfers got %0d required %0d", xfers - n0, 1);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    send(32'hCAFE_0001, 1'b0);
    send(32'hCAFE_0002, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle("reset_mid");
    cur_n = 0; cur_data = '0; cur_plain = '0;
    n0 = xfers;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (xfers != n0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard got xfers=%0d v=%b required xfers=0 v=0", xfers - n0, out_valid);
    end
    send(32'h0BAD_F00D, 1'b0);
    send(32'h1234_5678, 1'b0);
    send(32'h9ABC_DEF0, 1'b0);
    send(32'h0F0F_F0F0, 1'b0);
    wait_drain();
  endtask

  task automatic test_random();
    int len;
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, NW);
      for (int i = 0; i < len; i++)
        send((b % 2 == 0) ? 32'h5A5A_A5A5 : 32'($urandom), (i == len - 1) && (len < NW || b % 3 == 0));
      wait_drain();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_block();
    test_partial();
    test_backpressure();
    test_single();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/msk_block_seq.md
MSK_BLOCK_SEQ -- requirements
Module: msk_block_seq

Interface
- REQ-001: The module SHALL have parameter d, default 2, the number of shares per masked bit.
- REQ-002: The module SHALL have parameter W, default 32, the number of unmasked bits per word.
- REQ-003: The module SHALL have parameter NW, default 4, the number of words per block; legal range is 2..16.
- REQ-004: The module SHALL have port clk, input, width 1: the single clock, with all state on its rising edge.
- REQ-005: The module SHALL have port rst_n, input, width 1: the reset, asynchronous and active-low.
- REQ-006: The module SHALL have port in_data, input, width W*d: one masked word, with bit i share j at index i*d+j.
- REQ-007: The module SHALL have ports in_valid (input, 1), in_last (input, 1) and in_ready (output, 1): the input word handshake, where in_last marks the final word of a message.
- REQ-008: The module SHALL have port out_data, output, width NW*W*d: the masked block, with word 0 at the least-significant end.
- REQ-009: The module SHALL have ports out_valid (output, 1) and out_ready (input, 1): the block handshake.
- REQ-010: The module SHALL have port out_nwords, output, width $clog2(NW+1): the count of valid words in out_data.
- REQ-011: The module SHALL have port out_last, output, width 1: asserted when the block closes a message.

Function
- REQ-012: The FSM SHALL have three states: IDLE, FILL and FULL.
- REQ-013: IDLE SHALL go to FILL on the first accepted word.
- REQ-014: FILL SHALL go to FULL when the NW-th word is accepted, or when any word is accepted with in_last=1.
- REQ-015: FULL SHALL go to IDLE on the out_valid & out_ready transfer.
- REQ-016: A word SHALL be accepted iff in_valid & in_ready at a rising clk edge; in_ready SHALL equal (state != FULL).
- REQ-017: An accepted word SHALL be written into slot wcnt, and wcnt SHALL increment; no other slot SHALL change, because each slot has its own enable.
- REQ-018: Latency: out_valid SHALL assert in the cycle after the closing word is accepted.
- REQ-019: out_valid SHALL equal (state == FULL), and out_data SHALL stay stable while out_valid=1 and out_ready=0.
- REQ-020: On a partial block (in_last accepted with wcnt+1 < NW), slots wcnt+1..NW-1 SHALL be filled per REQ-030/031 in the same edge.
- REQ-021: On a partial block, out_nwords SHALL be set to wcnt+1 and out_last to 1.
- REQ-022: On a full block, out_nwords SHALL equal NW; out_last SHALL be 1 only if the NW-th word carried in_last.
- REQ-023: wcnt SHALL return to 0 on the output transfer.
- REQ-024: A new word SHALL NOT be accepted in the cycle of an output transfer, i.e. no write-through; the next word is accepted one cycle later.
- REQ-025: Valid words SHALL be stored exactly as received: the sequencer SHALL never recombine shares or apply any logic across share indices.
- REQ-026: Control signals (in_valid, in_last, out_ready) SHALL be treated as non-sensitive.

Reset
- REQ-027: Asserting rst_n low SHALL asynchronously force state=IDLE, wcnt=0, out_valid=0, in_ready=1, out_nwords=0 and out_last=0.
- REQ-028: Reset SHALL also clear every slot, so that out_data reads 0.
- REQ-029: Reset mid-block SHALL discard the partial block, with no output emitted after release.

Configuration
- REQ-030: With `MSK_BLOCK_SEQ_PAD_EN defined, on a partial block slot wcnt+1 SHALL receive constant 1 in bit 0 share 0, with all other bits and shares 0; remaining slots SHALL be 0.
- REQ-031: Without the macro, all padding slots SHALL be 0 across every share.
- REQ-032: Under both settings, a block of exactly NW words SHALL receive no padding.

Structure
- REQ-033: Package msk_seq_pkg SHALL hold the state enum (IDLE/FILL/FULL) and the width helper for out_nwords.
- REQ-034: There SHALL be one sub-module, msk_word_slot: a W*d-bit masked register with a per-slot load enable and a per-slot clear, instantiated NW times.

Verification
- REQ-035: Scenario: d=2, W=32, NW=4; send words A,B,C,D, no in_last -> out_valid the next cycle, out_data={D,C,B,A}, out_nwords=4, out_last=0.
- REQ-036: Scenario: send A,B with in_last on B -> out_nwords=2, out_last=1; slot2 = 0x…01 on share 0 with PAD_EN, else 0; slot3=0.
- REQ-037: Scenario: hold out_ready=0 for 5 cycles while FULL -> in_ready=0 and out_data unchanged; after out_ready=1 for one cycle -> IDLE, next word lands in slot 0.
- REQ-038: Scenario: single word with in_last -> out_nwords=1, and exactly one output transfer occurs.
- REQ-039: Scenario: deassert rst_n after 2 accepted words -> out_valid=0 and out_data=0 immediately; a subsequent 4-word block is emitted correctly with no stale data.
- REQ-040: Scenario: randomized share values with a fixed unmasked value -> XOR of the shares of each output word equals the input word.
